// File: rtl/vi_crcblock_pkg.sv
// Shared types and constants for the crcblock EMR reader.
package vi_crcblock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } emr_rd_state_t;

    localparam int unsigned EMR_WIDTH_DEFAULT = 68;
    localparam int unsigned LOAD_CYCLES_MIN   = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vi_crcblock_emr_reader_if.sv
// Core-side bundle of the EMR reader: EMR handshake plus error statistics.
interface vi_crcblock_emr_reader_if #(
    parameter int unsigned EMR_WIDTH = 68,
    parameter int unsigned CNT_WIDTH = 16
) ();

    logic [EMR_WIDTH-1:0] emr;
    logic                 emr_valid;
    logic                 emr_ack;
    logic                 crc_error_event;
    logic                 busy;
    logic [CNT_WIDTH-1:0] error_count;
    logic                 overflow;
    logic                 clear;

    modport master (
        output emr, emr_valid, crc_error_event, busy, error_count, overflow,
        input  emr_ack, clear
    );

    modport slave (
        input  emr, emr_valid, crc_error_event, busy, error_count, overflow,
        output emr_ack, clear
    );

endinterface

// File: rtl/vi_sync_edge.sv
// Multi-flop synchronizer followed by a rising-edge detector on the synchronized level.
module vi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_fr,
    input  logic rst_fr_n,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d_q;

    always_ff @(posedge clk_fr or negedge rst_fr_n) begin
        if (!rst_fr_n) begin
            sync_q    <= '0;
            level_d_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], d};
            level_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_d_q;

endmodule

// File: rtl/vi_crcblock_emr_reader.sv
// Loads and serially reads the crcblock atom's EMR on each CRC error, then hands it to core logic.
module vi_crcblock_emr_reader
    import vi_crcblock_pkg::*;
#(
    parameter int unsigned EMR_WIDTH   = EMR_WIDTH_DEFAULT,
    parameter int unsigned LOAD_CYCLES = LOAD_CYCLES_MIN,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic clk_fr,
    input  logic rst_fr_n,
    input  logic crc_error,
    input  logic regout,
    output logic shiftnld,
    vi_crcblock_emr_reader_if.master emr_if
);

    localparam int unsigned CW = $clog2(max_u(EMR_WIDTH, LOAD_CYCLES) + 1);
    localparam logic [CW-1:0] LOAD_INIT  = CW'(LOAD_CYCLES - 1);
    localparam logic [CW-1:0] SHIFT_LAST = CW'(EMR_WIDTH - 1);

    emr_rd_state_t        state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 pending_q, pending_d;
    logic [EMR_WIDTH-1:0] shreg_q, emr_q;
    logic                 emr_valid_q;
    logic                 event_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 overflow_q;
    logic                 sync_level;
    logic                 rise;
    logic                 shift_en;
    logic                 capture;
    logic                 ack_take;
    logic                 ovf_set;

    vi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_fr   (clk_fr),
        .rst_fr_n (rst_fr_n),
        .d        (crc_error),
        .level    (sync_level),
        .rise     (rise)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        shiftnld  = 1'b1;
        shift_en  = 1'b0;
        capture   = 1'b0;
        ack_take  = 1'b0;
        ovf_set   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rise || pending_q) begin
                    state_d   = LOAD;
                    cnt_d     = LOAD_INIT;
                    pending_d = 1'b0;
                end
            end
            LOAD: begin
                shiftnld = 1'b0;
                if (cnt_q == '0) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt_q == SHIFT_LAST) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (emr_ack_in()) begin
                    ack_take = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // One-deep queue for errors arriving mid-read; a second one is only recorded as overflow.
        if (rise && (state_q != IDLE)) begin
            if (pending_q) ovf_set = 1'b1;
            else           pending_d = 1'b1;
        end
    end

    function automatic logic emr_ack_in();
        return emr_if.emr_ack;
    endfunction

    always_ff @(posedge clk_fr or negedge rst_fr_n) begin
        if (!rst_fr_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            shreg_q     <= '0;
            emr_q       <= '0;
            emr_valid_q <= 1'b0;
            event_q     <= 1'b0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            event_q   <= rise;
            if (shift_en) shreg_q <= {regout, shreg_q[EMR_WIDTH-1:1]};
            if (capture) begin
                emr_q       <= {regout, shreg_q[EMR_WIDTH-1:1]};
                emr_valid_q <= 1'b1;
            end else if (ack_take) begin
                emr_valid_q <= 1'b0;
            end
            if (emr_if.clear)                count_q <= '0;
            else if (event_q && !(&count_q)) count_q <= count_q + 1'b1;
            if (emr_if.clear)  overflow_q <= 1'b0;
            else if (ovf_set)  overflow_q <= 1'b1;
        end
    end

    assign emr_if.emr             = emr_q;
    assign emr_if.emr_valid       = emr_valid_q;
    assign emr_if.crc_error_event = event_q;
    assign emr_if.busy            = (state_q != IDLE);
    assign emr_if.error_count     = count_q;
    assign emr_if.overflow        = overflow_q;

    logic unused_level;
    assign unused_level = sync_level;

endmodule

// File: tb/tb_vi_crcblock_emr_reader.sv
// Directed plus randomized bench for the EMR reader, with a behavioural model of the crcblock atom.
module tb_vi_crcblock_emr_reader;
    import vi_crcblock_pkg::*;

    localparam int unsigned EW = 68;
    localparam int unsigned CW = 4;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    logic clk_fr   = 1'b0;
    logic rst_fr_n = 1'b0;
    logic crc_error = 1'b0;
    logic regout;
    logic shiftnld;

    logic [EW-1:0] atom_pat = '0;
    logic [EW-1:0] atom_q   = '0;

    int n_checks = 0;
    int n_err    = 0;
    int cnt_model = 0;

    vi_crcblock_emr_reader_if #(.EMR_WIDTH(EW), .CNT_WIDTH(CW)) bus ();

    vi_crcblock_emr_reader #(
        .EMR_WIDTH   (EW),
        .LOAD_CYCLES (2),
        .SYNC_STAGES (2),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk_fr    (clk_fr),
        .rst_fr_n  (rst_fr_n),
        .crc_error (crc_error),
        .regout    (regout),
        .shiftnld  (shiftnld),
        .emr_if    (bus)
    );

    always #5 clk_fr = ~clk_fr;

    // Atom user shift register: parallel load while shiftnld=0, shift toward regout otherwise.
    always @(posedge clk_fr) begin
        if (!shiftnld) atom_q <= atom_pat;
        else           atom_q <= atom_q >> 1;
    end
    assign regout = atom_q[0];

    task automatic tick();
        @(posedge clk_fr);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] rand_pat();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[EW-1:0];
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= int'(CNT_MAX)) ? int'(CNT_MAX) : c + 1;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [EW-1:0] p1, pa, pb, pat, held_emr;
        logic seen_valid, prev_valid;
        int ev_seen, caps, quiet, ack_d, gap;
        bit drained;

        bus.emr_ack = 1'b0;
        bus.clear   = 1'b0;
        repeat (3) tick();
        chkv("rst_emr", bus.emr, '0);
        chk1("rst_valid", bus.emr_valid, 1'b0);
        chk1("rst_shiftnld", shiftnld, 1'b1);
        chk1("rst_event", bus.crc_error_event, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chkv("rst_count", EW'(bus.error_count), EW'(0));
        chk1("rst_overflow", bus.overflow, 1'b0);
        rst_fr_n = 1'b1;
        repeat (2) tick();

        // Single error: first edge sampling crc_error=1 is edge 0.
        p1 = 68'h5_A5A5_0000_C001_C0DE;
        atom_pat  = p1;
        crc_error = 1'b1;
        for (int e = 0; e <= 72; e++) begin
            tick();
            if (e == 5) crc_error = 1'b0;
            if (e == 1) chk1("s_busy_e1", bus.busy, 1'b0);
            if (e == 2) begin
                chk1("s_event_e2", bus.crc_error_event, 1'b1);
                chk1("s_shiftnld_e2", shiftnld, 1'b0);
                chk1("s_busy_e2", bus.busy, 1'b1);
            end
            if (e == 3) begin
                chk1("s_event_e3", bus.crc_error_event, 1'b0);
                chk1("s_shiftnld_e3", shiftnld, 1'b0);
            end
            if (e == 4) chk1("s_shiftnld_e4", shiftnld, 1'b1);
            if (e == 71) chk1("s_valid_e71", bus.emr_valid, 1'b0);
        end
        cnt_model = sat_inc(cnt_model);
        chk1("s_valid_e72", bus.emr_valid, 1'b1);
        chkv("s_emr", bus.emr, p1);
        chkv("s_count", EW'(bus.error_count), EW'(cnt_model));

        // Ack handshake with a 10-cycle hold.
        for (int i = 0; i < 10; i++) begin
            tick();
            chkv("ack_hold_emr", bus.emr, p1);
            chk1("ack_hold_valid", bus.emr_valid, 1'b1);
        end
        bus.emr_ack = 1'b1;
        tick();
        bus.emr_ack = 1'b0;
        chk1("ack_valid_drop", bus.emr_valid, 1'b0);
        tick();
        chk1("ack_busy_after", bus.busy, 1'b0);
        chkv("ack_emr_kept", bus.emr, p1);

        // Back-to-back: second rise during SHIFT, third during DONE.
        pa = rand_pat();
        pb = rand_pat();
        atom_pat  = pa;
        crc_error = 1'b1;
        for (int e = 0; e <= 83; e++) begin
            tick();
            if (e == 5 || e == 25 || e == 82) crc_error = 1'b0;
            if (e == 19 || e == 77) crc_error = 1'b1;
            if (e == 23) chkv("b2b_count2", EW'(bus.error_count), EW'(cnt_model + 2));
            if (e == 72) begin
                chk1("b2b_validA", bus.emr_valid, 1'b1);
                chkv("b2b_emrA", bus.emr, pa);
            end
            if (e == 79) chk1("b2b_no_ovf_yet", bus.overflow, 1'b0);
        end
        cnt_model = sat_inc(sat_inc(sat_inc(cnt_model)));
        chk1("b2b_overflow", bus.overflow, 1'b1);
        chkv("b2b_count3", EW'(bus.error_count), EW'(cnt_model));
        atom_pat    = pb;
        bus.emr_ack = 1'b1;
        tick();
        bus.emr_ack = 1'b0;
        chk1("b2b_ack_valid", bus.emr_valid, 1'b0);
        chk1("b2b_ack_idle", bus.busy, 1'b0);
        tick();
        chk1("b2b_reload_busy", bus.busy, 1'b1);
        chk1("b2b_reload_load", shiftnld, 1'b0);
        for (int j = 2; j <= 71; j++) begin
            tick();
            if (j == 70) chk1("b2b_validB_early", bus.emr_valid, 1'b0);
        end
        chk1("b2b_validB", bus.emr_valid, 1'b1);
        chkv("b2b_emrB", bus.emr, pb);
        bus.emr_ack = 1'b1;
        tick();
        bus.emr_ack = 1'b0;
        repeat (5) tick();
        chk1("b2b_no_third", bus.busy, 1'b0);

        // Reset in SHIFT cycle 30.
        atom_pat  = rand_pat();
        crc_error = 1'b1;
        for (int e = 0; e <= 34; e++) begin
            tick();
            if (e == 5) crc_error = 1'b0;
        end
        chk1("rm_in_shift", bus.busy, 1'b1);
        rst_fr_n = 1'b0;
        #1;
        chkv("rm_emr", bus.emr, '0);
        chk1("rm_valid", bus.emr_valid, 1'b0);
        chk1("rm_shiftnld", shiftnld, 1'b1);
        chk1("rm_event", bus.crc_error_event, 1'b0);
        chk1("rm_busy", bus.busy, 1'b0);
        chkv("rm_count", EW'(bus.error_count), EW'(0));
        chk1("rm_overflow", bus.overflow, 1'b0);
        cnt_model = 0;
        repeat (2) tick();
        rst_fr_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            seen_valid = seen_valid | bus.emr_valid | bus.busy;
        end
        chk1("rm_quiet_after", seen_valid, 1'b0);

        // Saturation: 17 edges with acks always asserted.
        bus.emr_ack = 1'b1;
        for (int p = 0; p < 17; p++) begin
            crc_error = 1'b1;
            repeat (4) tick();
            crc_error = 1'b0;
            repeat (4) tick();
            cnt_model = sat_inc(cnt_model);
        end
        repeat (5) tick();
        chkv("sat_count", EW'(bus.error_count), EW'(cnt_model));
        chk1("sat_overflow", bus.overflow, 1'b1);
        crc_error = 1'b1;
        repeat (3) tick();
        chk1("clr_event_now", bus.crc_error_event, 1'b1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        crc_error = 1'b0;
        cnt_model = 0;
        chkv("clr_count", EW'(bus.error_count), EW'(cnt_model));
        chk1("clr_overflow", bus.overflow, 1'b0);
        drained = 1'b0;
        quiet = 0;
        for (int i = 0; i < 600 && !drained; i++) begin
            tick();
            quiet = bus.busy ? 0 : quiet + 1;
            if (quiet >= 3) drained = 1'b1;
        end
        chk1("sat_drain", drained, 1'b1);
        chkv("clr_count_after", EW'(bus.error_count), EW'(cnt_model));

        // Level-held crc_error: one event, one capture.
        pat = rand_pat();
        atom_pat  = pat;
        crc_error = 1'b1;
        ev_seen = 0;
        caps = 0;
        prev_valid = 1'b0;
        held_emr = '0;
        for (int i = 0; i < 500; i++) begin
            tick();
            ev_seen += int'(bus.crc_error_event);
            if (bus.emr_valid && !prev_valid) begin
                caps++;
                held_emr = bus.emr;
            end
            prev_valid = bus.emr_valid;
        end
        crc_error = 1'b0;
        repeat (5) tick();
        bus.emr_ack = 1'b0;
        cnt_model = sat_inc(cnt_model);
        chkv("lvl_events", EW'(ev_seen), EW'(1));
        chkv("lvl_caps", EW'(caps), EW'(1));
        chkv("lvl_emr", held_emr, pat);
        chkv("lvl_count", EW'(bus.error_count), EW'(cnt_model));

        // Randomized captures with random ack timing, including ack held across DONE entry.
        for (int it = 0; it < 6; it++) begin
            pat   = rand_pat();
            ack_d = int'($urandom_range(0, 4));
            atom_pat  = pat;
            crc_error = 1'b1;
            for (int e = 0; e <= 72; e++) begin
                tick();
                if (e == 5) crc_error = 1'b0;
                if (e == 70 && ack_d == 0) bus.emr_ack = 1'b1;
                if (e == 71) chk1("rnd_valid_early", bus.emr_valid, 1'b0);
            end
            cnt_model = sat_inc(cnt_model);
            chk1("rnd_valid", bus.emr_valid, 1'b1);
            chkv("rnd_emr", bus.emr, pat);
            chkv("rnd_count", EW'(bus.error_count), EW'(cnt_model));
            if (ack_d != 0) begin
                repeat (ack_d) tick();
                chk1("rnd_valid_held", bus.emr_valid, 1'b1);
                bus.emr_ack = 1'b1;
            end
            tick();
            bus.emr_ack = 1'b0;
            chk1("rnd_valid_drop", bus.emr_valid, 1'b0);
            gap = int'($urandom_range(1, 10));
            repeat (gap) tick();
            chk1("rnd_idle", bus.busy, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
